// File: rtl/neg_abs_pipe.sv
// neg_abs_pipe: two-stage multi-lane pass/negate/abs/-abs unit with width conversion and overflow flags.
// Define NEG_ABS_PIPE_SATURATE_EN to clamp overflowing lanes; otherwise the result wraps.
module neg_abs_pipe #(
  parameter int NCH = 4,
  parameter int BW_IN = 32,
  parameter int BW_OUT = 32,
  parameter int IN_SIGNED = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [NCH*BW_IN-1:0]    s_data,
  input  logic [1:0]              s_mode,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [NCH*BW_OUT-1:0]   m_data,
  output logic [NCH-1:0]          m_ovf,
  output logic [NCH-1:0]          ovf_sticky,
  input  logic                    ovf_clr
);
  localparam int W = (BW_IN > BW_OUT ? BW_IN : BW_OUT) + 2;
  localparam logic signed [W-1:0] MAX_V = {{(W-BW_OUT+1){1'b0}}, {(BW_OUT-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_V = {{(W-BW_OUT+1){1'b1}}, {(BW_OUT-1){1'b0}}};
  logic v1, v2, ld1, ld2;
  logic [1:0] mode1;
  logic signed [W-1:0] x1 [NCH];
  logic signed [W-1:0] ext [NCH];
  logic signed [W-1:0] ax [NCH];
  logic signed [W-1:0] r [NCH];
  logic [NCH*BW_OUT-1:0] res;
  logic [NCH-1:0] ovf;
  // s_ready is combinational from m_ready so a full pipeline still streams one beat per cycle
  assign ld2 = !v2 || m_ready;
  assign ld1 = !v1 || ld2;
  assign s_ready = ld1;
  assign m_valid = v2;
  always_comb begin
    res = '0;
    ovf = '0;
    for (int i = 0; i < NCH; i++) begin
      ext[i] = {{(W-BW_IN){(IN_SIGNED != 0) && s_data[i*BW_IN+BW_IN-1]}}, s_data[i*BW_IN +: BW_IN]};
      ax[i] = x1[i][W-1] ? -x1[i] : x1[i];
      r[i] = mode1 == 2'd0 ? x1[i] : mode1 == 2'd1 ? -x1[i] : mode1 == 2'd2 ? ax[i] : -ax[i];
      ovf[i] = (r[i] > MAX_V) || (r[i] < MIN_V);
`ifdef NEG_ABS_PIPE_SATURATE_EN
      res[i*BW_OUT +: BW_OUT] = !ovf[i] ? r[i][BW_OUT-1:0] : r[i] > 0 ? MAX_V[BW_OUT-1:0] : MIN_V[BW_OUT-1:0];
`else
      res[i*BW_OUT +: BW_OUT] = r[i][BW_OUT-1:0];
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      mode1 <= '0;
      for (int i = 0; i < NCH; i++) x1[i] <= '0;
      m_data <= '0;
      m_ovf <= '0;
      ovf_sticky <= '0;
    end else begin
      if (ld1) v1 <= s_valid;
      if (ld1 && s_valid) begin
        mode1 <= s_mode;
        for (int i = 0; i < NCH; i++) x1[i] <= ext[i];
      end
      if (ld2) v2 <= v1;
      if (ld2 && v1) begin
        m_data <= res;
        m_ovf <= ovf;
      end
      ovf_sticky <= ({NCH{v2 && m_ready}} & m_ovf) | (ovf_sticky & ~{NCH{ovf_clr}});
    end
  end
endmodule

// File: tb/tb_neg_abs_pipe.sv
// tb_neg_abs_pipe: directed vectors over three lane configurations plus stall, sticky and reset sequences.
module tb_neg_abs_pipe;
`ifdef NEG_ABS_PIPE_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0, m_ready = 1'b1, ovf_clr = 1'b0;
  logic [15:0] s_data = '0;
  logic [1:0] s_mode = '0;
  logic sr0, sr1, sr2, mv0, mv1, mv2;
  logic [15:0] md0, md1;
  logic [23:0] md2;
  logic [1:0] mo0, mo1, mo2, st0, st1, st2;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  neg_abs_pipe #(.NCH(2), .BW_IN(8), .BW_OUT(8), .IN_SIGNED(1)) u0 (.clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(sr0), .s_data(s_data), .s_mode(s_mode), .m_valid(mv0),
    .m_ready(m_ready), .m_data(md0), .m_ovf(mo0), .ovf_sticky(st0), .ovf_clr(ovf_clr));
  neg_abs_pipe #(.NCH(2), .BW_IN(8), .BW_OUT(8), .IN_SIGNED(0)) u1 (.clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(sr1), .s_data(s_data), .s_mode(s_mode), .m_valid(mv1),
    .m_ready(m_ready), .m_data(md1), .m_ovf(mo1), .ovf_sticky(st1), .ovf_clr(ovf_clr));
  neg_abs_pipe #(.NCH(2), .BW_IN(8), .BW_OUT(12), .IN_SIGNED(1)) u2 (.clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(sr2), .s_data(s_data), .s_mode(s_mode), .m_valid(mv2),
    .m_ready(m_ready), .m_data(md2), .m_ovf(mo2), .ovf_sticky(st2), .ovf_clr(ovf_clr));
  typedef struct {
    logic [1:0] mode;
    logic [15:0] d;
    logic [15:0] e0;
    logic [1:0] o0;
    logic [15:0] e1;
    logic [1:0] o1;
    logic [23:0] e2;
    logic [1:0] o2;
  } vec_t;
  vec_t tbl [5];
  logic [15:0] bp [5];
  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic send(input logic [15:0] d, input logic [1:0] mode);
    @(negedge clk);
    s_valid = 1'b1;
    s_data = d;
    s_mode = mode;
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    int in_i, out_i;
    tbl[0] = '{2'd1, 16'h8005, SAT ? 16'h7FFB : 16'h80FB, 2'b10, 16'h80FB, 2'b00, 24'h080FFB, 2'b00};
    tbl[1] = '{2'd2, 16'hFB7F, 16'h057F, 2'b00, SAT ? 16'h7F7F : 16'hFB7F, 2'b10, 24'h00507F, 2'b00};
    tbl[2] = '{2'd3, 16'h0580, 16'hFB80, 2'b00, 16'hFB80, 2'b00, 24'hFFBF80, 2'b00};
    tbl[3] = '{2'd1, 16'hC800, 16'h3800, 2'b00, SAT ? 16'h8000 : 16'h3800, 2'b10, 24'h038000, 2'b00};
    tbl[4] = '{2'd0, 16'h7F80, 16'h7F80, 2'b00, SAT ? 16'h7F7F : 16'h7F80, 2'b01, 24'h07FF80, 2'b00};
    for (int k = 0; k < 5; k++) bp[k] = {8'(k + 1), 8'(8'h10 + k)};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_mvalid", {mv0, mv1, mv2}, 0);
    chk("rst_data0", md0, 0);
    chk("rst_data2", md2, 0);
    chk("rst_ovf", {mo0, mo1, mo2}, 0);
    chk("rst_sticky", {st0, st1, st2}, 0);
    chk("rst_sready", {sr0, sr1, sr2}, 24'h7);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data = tbl[k].d;
      s_mode = tbl[k].mode;
      @(negedge clk);
      s_valid = 1'b0;
      chk("lat1_mvalid", mv0, 0);
      @(negedge clk);
      chk("lat2_mvalid", {mv0, mv1, mv2}, 24'h7);
      chk($sformatf("v%0d_data_s8", k), md0, tbl[k].e0);
      chk($sformatf("v%0d_ovf_s8", k), mo0, tbl[k].o0);
      chk($sformatf("v%0d_data_u8", k), md1, tbl[k].e1);
      chk($sformatf("v%0d_ovf_u8", k), mo1, tbl[k].o1);
      chk($sformatf("v%0d_data_s12", k), md2, tbl[k].e2);
      chk($sformatf("v%0d_ovf_s12", k), mo2, tbl[k].o2);
    end
    @(negedge clk);
    chk("bubble_mvalid", mv0, 0);
    chk("bubble_hold", md0, tbl[4].e0);
    chk("sticky_u8_accum", st1, 2'b11);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("sticky_cleared", {st0, st1}, 0);
    send(16'h8005, 2'd1);
    @(negedge clk);
    chk("sticky_set", st0, 2'b10);
    send(16'h8005, 2'd1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("sticky_set_wins", st0, 2'b10);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("sticky_clr_alone", st0, 2'b00);
    in_i = 0;
    out_i = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      s_valid = in_i < 5;
      s_data = bp[in_i < 5 ? in_i : 0];
      s_mode = 2'd0;
      m_ready = !(c >= 3 && c <= 6);
      #1;
      if (c >= 3 && c <= 6) chk("bp_sready_low", sr0, 0);
      if (mv0 && !m_ready && out_i < 5) chk("bp_hold", md0, bp[out_i]);
      if (mv0 && m_ready) begin
        if (out_i < 5) chk("bp_order", md0, bp[out_i]);
        else chk("bp_extra_beat", mv0, 0);
        out_i++;
      end
      if (s_valid && sr0) in_i++;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    chk("bp_out_count", 24'(out_i), 24'd5);
    chk("bp_in_count", 24'(in_i), 24'd5);
    m_ready = 1'b0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data = 16'h1111;
    @(negedge clk);
    s_data = 16'h2222;
    @(negedge clk);
    s_valid = 1'b0;
    chk("rst_pre_full", mv0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_mvalid", {mv0, mv1, mv2}, 0);
    chk("rst_mid_data", md0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst_no_stale", {mv0, mv1, mv2}, 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
